// File: rtl/frame_packer_pkg.sv
// Shared constants for the 24->32 frame packer and the host-side unpacker.
// State encoding and frame header layout.
package frame_packer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_HDR = 3'd0;
    localparam state_t S_P0  = 3'd1;
    localparam state_t S_P1  = 3'd2;
    localparam state_t S_P2  = 3'd3;
    localparam state_t S_P3  = 3'd4;

    localparam logic [15:0] HDR_MAGIC_DEF = 16'hF5A5;
    localparam int          HDR_MAGIC_LSB = 16;

endpackage

// File: rtl/frame_packer_24to32.sv
// Packs 24-bit pipe words four-at-a-time into three dense 32-bit words,
// prefixes each frame with a counted header and tracks dropped outputs.
module frame_packer_24to32
    import frame_packer_pkg::*;
#(
    parameter int          FRAME_WORDS = 4096,
    parameter logic [15:0] HDR_MAGIC   = HDR_MAGIC_DEF,
    parameter int          CNT_W       = 13
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic [23:0] in_data,
    input  logic        in_valid,
    input  logic        out_full,
    output logic [31:0] out_data,
    output logic        out_valid,
    output logic [15:0] frame_cnt,
    output logic        frame_done,
    output logic        overflow,
    output logic [15:0] drop_cnt
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME_WORDS - 1);

    generate
        if ((FRAME_WORDS % 4) != 0 || FRAME_WORDS < 4 ||
            (64'd1 << CNT_W) < 64'(FRAME_WORDS)) begin : g_bad_cfg
            $error("frame_packer_24to32: bad FRAME_WORDS/CNT_W");
        end
    endgenerate

    state_t           state;
    state_t           state_d;
    logic [23:0]      res;
    logic [23:0]      res_d;
    logic [CNT_W-1:0] wcnt;
    logic             emit;
    logic [31:0]      word;
    logic             accept;
    logic             frame_end;

    assign accept    = in_valid && !flush;
    assign frame_end = accept && (wcnt == LAST);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_HDR;
        end else begin
            state <= state_d;
        end
    end

    // Next-state: advance one packing phase per accepted word
    always_comb begin
        state_d = state;
        if (flush) begin
            state_d = S_HDR;
        end else if (in_valid) begin
            case (state)
                S_HDR:   state_d = S_P1;
                S_P0:    state_d = S_P1;
                S_P1:    state_d = S_P2;
                S_P2:    state_d = S_P3;
                S_P3:    state_d = frame_end ? S_HDR : S_P0;
                default: state_d = S_HDR;
            endcase
        end
    end

    // Output decode: word to emit this phase and the leftover bytes
    always_comb begin
        emit  = 1'b0;
        word  = '0;
        res_d = res;
        if (flush) begin
            res_d = '0;
        end else if (in_valid) begin
            case (state)
                S_HDR: begin
                    emit = 1'b1;
                    word[31:HDR_MAGIC_LSB]  = HDR_MAGIC;
                    word[HDR_MAGIC_LSB-1:0] = frame_cnt;
                    res_d = in_data;
                end
                S_P0: begin
                    res_d = in_data;
                end
                S_P1: begin
                    emit  = 1'b1;
                    word  = {in_data[7:0], res};
                    res_d = {8'h00, in_data[23:8]};
                end
                S_P2: begin
                    emit  = 1'b1;
                    word  = {in_data[15:0], res[15:0]};
                    res_d = {16'h0000, in_data[23:16]};
                end
                S_P3: begin
                    emit = 1'b1;
                    word = {in_data, res[7:0]};
                end
                default: begin
                    emit = 1'b0;
                end
            endcase
        end
    end

    // Residual bytes and position within the frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res  <= '0;
            wcnt <= '0;
        end else begin
            res <= res_d;
            if (flush) begin
                wcnt <= '0;
            end else if (in_valid) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + 1'b1;
            end
        end
    end

    // Registered outputs, frame counter and drop accounting
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            out_valid  <= emit && !out_full;
            frame_done <= frame_end;
            if (emit && !out_full) begin
                out_data <= word;
            end
            if (frame_end) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            if (emit && out_full) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_packer_24to32.sv
// Randomised and directed checks of the 24->32 frame packer
// against a bit-stream reference model.
module tb_frame_packer_24to32;

    localparam int FW = 8;

    logic        clk      = 1'b0;
    logic        clk_en   = 1'b0;
    logic        rst      = 1'b0;
    logic        flush    = 1'b0;
    logic [23:0] in_data  = '0;
    logic        in_valid = 1'b0;
    logic        out_full = 1'b0;
    logic [31:0] out_data;
    logic        out_valid;
    logic [15:0] frame_cnt;
    logic        frame_done;
    logic        overflow;
    logic [15:0] drop_cnt;

    int n_vec = 0;
    int n_err = 0;

    // reference model state
    int          m_idx;
    int          m_nb;
    logic [63:0] m_acc;
    logic [15:0] m_fcnt;
    logic [15:0] m_drop;
    logic        m_ovf;
    logic        e_valid;
    logic        e_done;
    logic [31:0] e_data;

    frame_packer_24to32 #(
        .FRAME_WORDS(FW),
        .HDR_MAGIC  (16'hF5A5),
        .CNT_W      (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_full  (out_full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .frame_cnt (frame_cnt),
        .frame_done(frame_done),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    always #5 if (clk_en) clk = ~clk;

    task automatic mdl_reset();
        m_idx   = 0;
        m_nb    = 0;
        m_acc   = '0;
        m_fcnt  = '0;
        m_drop  = '0;
        m_ovf   = 1'b0;
        e_valid = 1'b0;
        e_done  = 1'b0;
        e_data  = '0;
    endtask

    // little-endian bit stream: 24 bits in, 32 bits out when available
    task automatic mdl(input logic v, input logic [23:0] d,
                       input logic full, input logic fl);
        logic        have;
        logic [31:0] w;
        have    = 1'b0;
        w       = '0;
        e_valid = 1'b0;
        e_done  = 1'b0;
        if (fl) begin
            m_idx = 0;
            m_acc = '0;
            m_nb  = 0;
        end else if (v) begin
            if (m_idx == 0) begin
                w     = {16'hF5A5, m_fcnt};
                have  = 1'b1;
                m_acc = 64'(d);
                m_nb  = 24;
            end else begin
                m_acc = m_acc | (64'(d) << m_nb);
                m_nb  = m_nb + 24;
                if (m_nb >= 32) begin
                    w     = m_acc[31:0];
                    m_acc = m_acc >> 32;
                    m_nb  = m_nb - 32;
                    have  = 1'b1;
                end
            end
            if (have) begin
                if (full) begin
                    m_ovf = 1'b1;
                    if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
                end else begin
                    e_valid = 1'b1;
                    e_data  = w;
                end
            end
            m_idx = m_idx + 1;
            if (m_idx == FW) begin
                m_idx  = 0;
                m_fcnt = m_fcnt + 16'd1;
                e_done = 1'b1;
            end
        end
    endtask

    task automatic cyc(input logic v, input logic [23:0] d,
                       input logic full, input logic fl);
        @(negedge clk);
        in_valid = v;
        in_data  = d;
        out_full = full;
        flush    = fl;
        mdl(v, d, full, fl);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_full = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 ||
            frame_cnt !== 16'h0 || frame_done !== 1'b0 ||
            overflow !== 1'b0 || drop_cnt !== 16'h0) begin
            n_err++;
            $display("FAIL reset_async: v=%b d=%h fc=%h fd=%b ov=%b dc=%h, required all 0",
                     out_valid, out_data, frame_cnt, frame_done, overflow, drop_cnt);
        end
        mdl_reset();
        clk_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 24'h0, 1'b0, 1'b0);
            n_vec++;
            if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
                n_err++;
                $display("FAIL reset_idle: out_valid=%b frame_done=%b, required 0 0",
                         out_valid, frame_done);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ins [4];
        logic [31:0] exp [4];
        logic [23:0] r;
        ins = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        exp = '{32'hF5A50000, 32'h22111111, 32'h33332222, 32'h44444433};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ins[i], 1'b0, 1'b0);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_err++;
                $display("FAIL b2b_word%0d: valid=%b data=%h, required 1 %h",
                         i, out_valid, out_data, exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            r = 24'($urandom);
            cyc(1'b1, r, 1'b0, 1'b0);
            n_vec++;
            if (out_valid !== e_valid || (e_valid && out_data !== e_data) ||
                frame_done !== e_done) begin
                n_err++;
                $display("FAIL b2b_tail%0d: v=%b d=%h fd=%b, required %b %h %b",
                         i, out_valid, out_data, frame_done, e_valid, e_data, e_done);
            end
        end
        n_vec++;
        if (frame_done !== 1'b1 || frame_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL b2b_frame_end: frame_done=%b frame_cnt=%0d, required 1 1",
                     frame_done, frame_cnt);
        end
        cyc(1'b0, 24'h0, 1'b0, 1'b0);
        n_vec++;
        if (frame_done !== 1'b0 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_pulse: frame_done=%b out_valid=%b, required 0 0",
                     frame_done, out_valid);
        end
    endtask

    task automatic test_gaps();
        logic [23:0] ins [4];
        logic [31:0] exp [4];
        ins = '{24'h111111, 24'h222222, 24'h333333, 24'h444444};
        exp = '{{16'hF5A5, m_fcnt}, 32'h22111111, 32'h33332222, 32'h44444433};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, ins[i], 1'b0, 1'b0);
            n_vec++;
            if (out_valid !== 1'b1 || out_data !== exp[i]) begin
                n_err++;
                $display("FAIL gap_word%0d: valid=%b data=%h, required 1 %h",
                         i, out_valid, out_data, exp[i]);
            end
            for (int k = 0; k < 3; k++) begin
                cyc(1'b0, 24'h0, 1'b0, 1'b0);
                n_vec++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL gap_idle%0d_%0d: out_valid=%b, required 0",
                             i, k, out_valid);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
            n_vec++;
            if (out_valid !== e_valid || (e_valid && out_data !== e_data)) begin
                n_err++;
                $display("FAIL gap_tail%0d: v=%b d=%h, required %b %h",
                         i, out_valid, out_data, e_valid, e_data);
            end
        end
    endtask

    task automatic test_frame();
        logic [15:0] fc0;
        int          pulses;
        fc0    = frame_cnt;
        pulses = 0;
        for (int i = 0; i < FW; i++) begin
            cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
            if (frame_done === 1'b1) pulses++;
            n_vec++;
            if (out_valid !== e_valid || (e_valid && out_data !== e_data)) begin
                n_err++;
                $display("FAIL frame_word%0d: v=%b d=%h, required %b %h",
                         i, out_valid, out_data, e_valid, e_data);
            end
        end
        n_vec++;
        if (pulses != 1 || frame_cnt !== fc0 + 16'd1) begin
            n_err++;
            $display("FAIL frame_count: pulses=%0d frame_cnt=%0d, required 1 %0d",
                     pulses, frame_cnt, fc0 + 16'd1);
        end
        cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== {16'hF5A5, fc0 + 16'd1}) begin
            n_err++;
            $display("FAIL frame_next_hdr: valid=%b data=%h, required 1 %h",
                     out_valid, out_data, {16'hF5A5, fc0 + 16'd1});
        end
        for (int i = 1; i < FW; i++) cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_flush();
        logic [15:0] fc0;
        fc0 = frame_cnt;
        cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
        cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
        cyc(1'b0, 24'h0, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL flush_only: out_valid=%b frame_done=%b, required 0 0",
                     out_valid, frame_done);
        end
        cyc(1'b1, 24'h5A5A5A, 1'b0, 1'b1);
        n_vec++;
        if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL flush_with_valid: out_valid=%b drop_cnt=%0d, required 0 0",
                     out_valid, drop_cnt);
        end
        cyc(1'b1, 24'hABCDEF, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== {16'hF5A5, fc0} ||
            frame_cnt !== fc0 || drop_cnt !== 16'd0) begin
            n_err++;
            $display("FAIL flush_hdr: v=%b d=%h fc=%0d dc=%0d, required 1 %h %0d 0",
                     out_valid, out_data, frame_cnt, drop_cnt, {16'hF5A5, fc0}, fc0);
        end
        cyc(1'b1, 24'h000001, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h01ABCDEF) begin
            n_err++;
            $display("FAIL flush_residual: valid=%b data=%h, required 1 01abcdef",
                     out_valid, out_data);
        end
        for (int i = 2; i < FW; i++) cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_overflow();
        cyc(1'b1, 24'h111111, 1'b0, 1'b0);
        cyc(1'b1, 24'h222222, 1'b0, 1'b0);
        cyc(1'b1, 24'h333333, 1'b1, 1'b0);
        n_vec++;
        if (out_valid !== 1'b0 || overflow !== 1'b1 || drop_cnt !== 16'd1) begin
            n_err++;
            $display("FAIL ovf_drop: v=%b ov=%b dc=%0d, required 0 1 1",
                     out_valid, overflow, drop_cnt);
        end
        cyc(1'b1, 24'h444444, 1'b0, 1'b0);
        n_vec++;
        if (out_valid !== 1'b1 || out_data !== 32'h44444433) begin
            n_err++;
            $display("FAIL ovf_align: valid=%b data=%h, required 1 44444433",
                     out_valid, out_data);
        end
        for (int i = 4; i < FW; i++) cyc(1'b1, 24'($urandom), 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic v;
        logic f;
        logic fl;
        for (int i = 0; i < 800; i++) begin
            v  = ($urandom % 4) != 0;
            f  = ($urandom % 6) == 0;
            fl = ($urandom % 50) == 0;
            cyc(v, 24'($urandom), f, fl);
            n_vec++;
            if (out_valid !== e_valid || (e_valid && out_data !== e_data) ||
                frame_done !== e_done || frame_cnt !== m_fcnt ||
                overflow !== m_ovf || drop_cnt !== m_drop) begin
                n_err++;
                $display("FAIL rand_%0d: v=%b d=%h fd=%b fc=%h ov=%b dc=%h, required %b %h %b %h %b %h",
                         i, out_valid, out_data, frame_done, frame_cnt, overflow, drop_cnt,
                         e_valid, e_data, e_done, m_fcnt, m_ovf, m_drop);
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_gaps();
        test_frame();
        test_flush();
        test_overflow();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
